mac_pass_sequencer: RTL and testbench
=====================================

# mac_pass_sequencer

Pass-level FSM controller for the dense-dense multiply datapath (two multiplier IPs, two adder IPs, two partial-sum BRAMs). It replaces the fixed one-hot shift-register timing with a handshaked sequencer. Each pass, it:
- loads one constant per lane;
- streams DEPTH operands through the multipliers;
- issues aligned partial-sum reads and writes, asserting adder bypass on the first pass;
- flags the final pass's adder outputs as the matrix product.

Both lanes share every control output.

## Interface
- DEPTH, 280: partial-sum entries per pass (operands streamed after each constant).
- PASSES, 560: passes per product; must be ≥1.
- AW, 9: BRAM address width; 2^AW ≥ DEPTH.
- MUL_LAT, 6: multiplier IP latency, operand in to P out.
- ADD_LAT, 2: adder IP latency, A/B in to S out.
- RD_LAT, 2: BRAM read latency, addrb/enb to doutb; RD_LAT ≤ MUL_LAT.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a product; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at completion.
- in_valid  in  1  datain1/datain2 carry a beat.
- in_ready  out  1  combinational; high in LOAD and STREAM.
- load_const  out  1  combinational = in_valid & in_ready in LOAD; datapath captures constants on this edge.
- bypass  out  1  adder BYPASS, aligned to adder input.
- rd_en  out  1  BRAM port-B enable.
- rd_addr  out  AW  BRAM port-B address.
- wr_en  out  1  BRAM port-A write enable.
- wr_addr  out  AW  BRAM port-A address.
- out_valid  out  1  adder output / wr data is a final product element.
- out_addr  out  AW  element index of the out_valid word.
- pass_idx  out  16  current pass, 0..PASSES-1.

## Operation
- States: IDLE, LOAD, STREAM, DRAIN, DONE.
- IDLE: start moves to LOAD and clears pass_idx.
- LOAD: one accepted beat (load_const) moves to STREAM and clears elem.
- STREAM:
  - Each accepted beat tags the element index elem (0..DEPTH-1) into the pipeline; elem then increments.
  - The accept with elem == DEPTH-1 moves to DRAIN.
  - A cycle with in_valid low inserts a bubble; the pipeline still advances every cycle.
- DRAIN: waits until the tag pipeline is empty, with no tagged beat still ahead of its write. Then:
  - pass_idx == PASSES-1 moves to DONE;
  - otherwise pass_idx increments and the FSM moves to LOAD.
- DONE: done=1 for one cycle, then IDLE.
- Tag pipeline: a shift line of {valid, elem, first, last} of length MUL_LAT+ADD_LAT; first = (pass_idx==0), last = (pass_idx==PASSES-1).
- Read: a tag at depth MUL_LAT-RD_LAT drives rd_en=1, rd_addr=elem.
- Adder input: a tag at depth MUL_LAT drives bypass=first.
- Write: a tag at depth MUL_LAT+ADD_LAT drives:
  - wr_en=1, wr_addr=elem;
  - out_valid=last, out_addr=elem.
- When no valid tag is at a depth, the matching outputs are 0. Addresses hold their last value.
- No wrap arithmetic: addresses never exceed DEPTH-1.
- start while busy: ignored.
- in_valid while in_ready=0: ignored, no accept.
- rst mid-operation: everything clears on assertion. No wr_en, out_valid or done follows reset. The partially written BRAM contents are don't-care.

## Timing
- Reset value of every output: 0. Reset values of pass_idx, elem and the tag line: 0.
- rd_en, rd_addr, bypass, wr_en, wr_addr, out_valid, out_addr, busy, done and pass_idx are registered.
- Latency from accept of element e in STREAM:
  - rd_en at +(MUL_LAT-RD_LAT) cycles;
  - bypass at +MUL_LAT;
  - wr_en at +(MUL_LAT+ADD_LAT).
- A pass writes address e before the next pass reads it, because DRAIN guarantees this.
- done asserts the cycle after the last out_valid.
- Minimum product time with in_valid held high: PASSES·(1+DEPTH+MUL_LAT+ADD_LAT+1) + 2 cycles.
- PASSES=1: bypass and out_valid are both set on the same writes.

## Configuration
- MACSEQ_STALL_CNT_EN defined:
  - Adds the output port stall_cnt (32 bits, reset 0).
  - stall_cnt counts cycles in LOAD/STREAM with in_valid=0.
  - It clears on start accepted in IDLE and saturates at 2^32-1.
- Not defined: no port and no counter logic; all other behaviour is identical.

## Test plan
- DEPTH=4, PASSES=3, in_valid held high, start pulse:
  - 12 wr_en cycles, with wr_addr 0,1,2,3 in each pass.
  - bypass is set on the first 4 writes only.
  - out_valid is set on the last 4 writes, with out_addr 0..3.
  - done is one cycle after the final write.
- Same config, in_valid toggled 1,0,1,0 in STREAM:
  - wr_en shows bubbles matching the input gaps.
  - Addresses stay in order.
  - Each rd_en for element e follows the previous pass's wr_en for e.
- PASSES=1, DEPTH=2: both writes carry bypass=1 and out_valid=1; pass_idx stays 0.
- rst asserted at the accept of elem 1 in pass 1:
  - All outputs are 0 from the reset edge.
  - No further wr_en occurs.
  - A following start produces a full, correct sequence from pass 0.
- start pulsed again mid-STREAM: no effect. The write count and done timing are identical to the first test.
- MACSEQ_STALL_CNT_EN defined, 5 idle cycles injected: stall_cnt=5 at done; a new start resets it to 0.

Source files
------------

// File: rtl/mac_pass_sequencer_if.sv
// Handshake and control bundle between the pass sequencer and the multiply datapath.
// Both lanes share every control signal carried here.
interface mac_pass_sequencer_if #(
  parameter int AW = 9
);
  logic          start;
  logic          busy;
  logic          done;
  logic          in_valid;
  logic          in_ready;
  logic          load_const;
  logic          bypass;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [15:0]   pass_idx;

  modport master (
    input  start, in_valid,
    output busy, done, in_ready, load_const, bypass,
    output rd_en, rd_addr, wr_en, wr_addr, out_valid, out_addr, pass_idx
  );

  modport slave (
    output start, in_valid,
    input  busy, done, in_ready, load_const, bypass,
    input  rd_en, rd_addr, wr_en, wr_addr, out_valid, out_addr, pass_idx
  );
endinterface

// File: rtl/mac_pass_sequencer.sv
// Pass-level sequencer for the dense-dense multiply datapath: constant load, operand stream, drain.
// Defining MACSEQ_STALL_CNT_EN adds the stall_cnt port counting input-starved LOAD/STREAM cycles.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | waiting for the per-lane constant beat
// STREAM | accepting DEPTH operand beats, tagging each with its element index
// DRAIN  | waiting for every tagged beat to reach its write
// DONE   | one-cycle completion pulse
module mac_pass_sequencer #(
  parameter int DEPTH   = 280,
  parameter int PASSES  = 560,
  parameter int AW      = 9,
  parameter int MUL_LAT = 6,
  parameter int ADD_LAT = 2,
  parameter int RD_LAT  = 2
) (
  input  logic clk,
  input  logic rst,
  mac_pass_sequencer_if.master bus
`ifdef MACSEQ_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);
  localparam int TL   = MUL_LAT + ADD_LAT;
  localparam int RD_D = MUL_LAT - RD_LAT;

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] elem;
    logic          first;
    logic          last;
  } tag_t;

  state_t        state;
  logic [AW-1:0] elem;
  tag_t          tag_q [1:TL];
  tag_t          pipe  [0:TL];
  logic          accept;
  logic          line_busy;

  assign bus.in_ready   = (state == LOAD) || (state == STREAM);
  assign accept         = bus.in_valid & bus.in_ready;
  assign bus.load_const = accept && (state == LOAD);

  // pipe[0] is the beat being accepted this cycle, pipe[d] the tag d cycles old.
  always_comb begin
    pipe[0]       = '0;
    pipe[0].valid = accept && (state == STREAM);
    pipe[0].elem  = elem;
    pipe[0].first = (bus.pass_idx == 16'd0);
    pipe[0].last  = (bus.pass_idx == 16'(PASSES - 1));
    for (int i = 1; i <= TL; i++) pipe[i] = tag_q[i];
  end

  always_comb begin
    line_busy = 1'b0;
    for (int i = 1; i <= TL; i++) line_busy = line_busy | tag_q[i].valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      elem          <= '0;
      for (int i = 1; i <= TL; i++) tag_q[i] <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.bypass    <= 1'b0;
      bus.rd_en     <= 1'b0;
      bus.rd_addr   <= '0;
      bus.wr_en     <= 1'b0;
      bus.wr_addr   <= '0;
      bus.out_valid <= 1'b0;
      bus.out_addr  <= '0;
      bus.pass_idx  <= '0;
    end else begin
      for (int i = TL; i > 1; i--) tag_q[i] <= tag_q[i-1];
      tag_q[1] <= pipe[0];

      bus.rd_en <= pipe[RD_D].valid;
      if (pipe[RD_D].valid) bus.rd_addr <= pipe[RD_D].elem;
      bus.bypass <= pipe[MUL_LAT].valid & pipe[MUL_LAT].first;
      bus.wr_en  <= pipe[TL].valid;
      if (pipe[TL].valid) bus.wr_addr <= pipe[TL].elem;
      bus.out_valid <= pipe[TL].valid & pipe[TL].last;
      if (pipe[TL].valid && pipe[TL].last) bus.out_addr <= pipe[TL].elem;

      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= LOAD;
            bus.busy     <= 1'b1;
            bus.pass_idx <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            state <= STREAM;
            elem  <= '0;
          end
        end
        STREAM: begin
          if (accept) begin
            if (elem == AW'(DEPTH - 1)) state <= DRAIN;
            else elem <= elem + 1'b1;
          end
        end
        // Leaving only once the line is empty keeps every write ahead of the next pass's read.
        DRAIN: begin
          if (!line_busy) begin
            if (bus.pass_idx == 16'(PASSES - 1)) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state        <= LOAD;
              bus.pass_idx <= bus.pass_idx + 16'd1;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MACSEQ_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && bus.start) begin
      stall_cnt <= '0;
    end else if (bus.in_ready && !bus.in_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mac_pass_sequencer.sv
// Bench for mac_pass_sequencer: a schedule model derived from pass/element timing rules
// predicts every control output per cycle for two configurations.
module tb_mac_pass_sequencer;
  localparam int AW = 9;
  localparam int ML = 6;
  localparam int AL = 2;
  localparam int RL = 2;
  localparam int TL = ML + AL;
  localparam int NC = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_pass_sequencer_if #(.AW(AW)) ia ();
  mac_pass_sequencer_if #(.AW(AW)) ib ();

`ifdef MACSEQ_STALL_CNT_EN
  logic [31:0] sc_a, sc_b;
`endif

  mac_pass_sequencer #(.DEPTH(4), .PASSES(3), .AW(AW), .MUL_LAT(ML), .ADD_LAT(AL), .RD_LAT(RL)) dut_a (
    .clk(clk), .rst(rst), .bus(ia)
`ifdef MACSEQ_STALL_CNT_EN
    , .stall_cnt(sc_a)
`endif
  );

  mac_pass_sequencer #(.DEPTH(2), .PASSES(1), .AW(AW), .MUL_LAT(ML), .ADD_LAT(AL), .RD_LAT(RL)) dut_b (
    .clk(clk), .rst(rst), .bus(ib)
`ifdef MACSEQ_STALL_CNT_EN
    , .stall_cnt(sc_b)
`endif
  );

  logic sel = 1'b0;
  logic o_busy, o_done, o_rdy, o_lc, o_byp, o_rd, o_wr, o_ov;
  logic [AW-1:0] o_ra, o_wa, o_oa;
  logic [15:0] o_pidx;
  assign o_busy = sel ? ib.busy      : ia.busy;
  assign o_done = sel ? ib.done      : ia.done;
  assign o_rdy  = sel ? ib.in_ready  : ia.in_ready;
  assign o_lc   = sel ? ib.load_const : ia.load_const;
  assign o_byp  = sel ? ib.bypass    : ia.bypass;
  assign o_rd   = sel ? ib.rd_en     : ia.rd_en;
  assign o_wr   = sel ? ib.wr_en     : ia.wr_en;
  assign o_ov   = sel ? ib.out_valid : ia.out_valid;
  assign o_ra   = sel ? ib.rd_addr   : ia.rd_addr;
  assign o_wa   = sel ? ib.wr_addr   : ia.wr_addr;
  assign o_oa   = sel ? ib.out_addr  : ia.out_addr;
  assign o_pidx = sel ? ib.pass_idx  : ia.pass_idx;

  // stimulus per cycle
  bit vpat [NC];
  bit vstart [NC];
  bit vrst [NC];
  bit vsel [NC];
  // expectations per cycle
  bit e_busy [NC], e_done [NC], e_rdy [NC], e_lc [NC], e_byp [NC], e_rd [NC], e_wr [NC], e_ov [NC];
  bit e_pchk [NC], e_zero [NC], e_scchk [NC];
  int e_ra [NC], e_wa [NC], e_oa [NC], e_pidx [NC], e_sc [NC];
  int acc_cyc [64];

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic clear_exp(input int a, input int b);
    for (int x = a; x <= b; x++) begin
      e_busy[x] = 0; e_done[x] = 0; e_rdy[x] = 0; e_lc[x] = 0; e_byp[x] = 0;
      e_rd[x] = 0; e_wr[x] = 0; e_ov[x] = 0; e_pchk[x] = 0; e_zero[x] = 0; e_scchk[x] = 0;
    end
  endtask

  // Walk the product as passes of {constant beat, DEPTH element beats, TL+1 drain cycles}
  // and project each accepted element to its read, adder-input and write cycles.
  // Nothing later than cycle kill is expected (reset is raised during that cycle).
  task automatic plan(input int s, input int depth, input int passes, input int kill, output int t_done);
    int t, t0, ns;
    ns = 0;
    vstart[s] = 1'b1;
    t = s + 1;
    for (int p = 0; p < passes && t <= kill; p++) begin
      t0 = t;
      while (!vpat[t]) begin ns++; t++; end
      if (t <= kill) e_lc[t] = 1;
      t++;
      for (int e = 0; e < depth; e++) begin
        while (!vpat[t]) begin ns++; t++; end
        acc_cyc[p*depth + e] = t;
        if (t < kill) begin
          if (t + ML - RL + 1 <= kill) begin e_rd[t+ML-RL+1] = 1; e_ra[t+ML-RL+1] = e; end
          if (p == 0 && t + ML + 1 <= kill) e_byp[t+ML+1] = 1;
          if (t + TL + 1 <= kill) begin
            e_wr[t+TL+1] = 1; e_wa[t+TL+1] = e;
            if (p == passes - 1) begin e_ov[t+TL+1] = 1; e_oa[t+TL+1] = e; end
          end
        end
        t++;
      end
      for (int x = t0; x < t; x++) if (x <= kill) e_rdy[x] = 1;
      for (int x = t0; x < t + TL + 1; x++) if (x <= kill) begin e_pchk[x] = 1; e_pidx[x] = p; end
      t += TL + 1;
    end
    t_done = t;
    for (int x = s + 1; x <= t_done; x++) if (x <= kill) e_busy[x] = 1;
    if (t_done <= kill) begin
      e_done[t_done] = 1;
      e_scchk[t_done] = 1; e_sc[t_done] = ns;
      e_pchk[t_done] = 1; e_pidx[t_done] = passes - 1;
    end
    e_scchk[s+1] = 1; e_sc[s+1] = 0;
  endtask

  task automatic check_cycle(input int k);
    chk("busy", k, 32'(o_busy), 32'(e_busy[k]));
    chk("done", k, 32'(o_done), 32'(e_done[k]));
    chk("in_ready", k, 32'(o_rdy), 32'(e_rdy[k]));
    chk("rd_en", k, 32'(o_rd), 32'(e_rd[k]));
    chk("bypass", k, 32'(o_byp), 32'(e_byp[k]));
    chk("wr_en", k, 32'(o_wr), 32'(e_wr[k]));
    chk("out_valid", k, 32'(o_ov), 32'(e_ov[k]));
    if (e_rd[k]) chk("rd_addr", k, 32'(o_ra), e_ra[k]);
    if (e_wr[k]) chk("wr_addr", k, 32'(o_wa), e_wa[k]);
    if (e_ov[k]) chk("out_addr", k, 32'(o_oa), e_oa[k]);
    if (e_pchk[k]) chk("pass_idx", k, 32'(o_pidx), e_pidx[k]);
    if (e_zero[k]) begin
      chk("rst_rd_addr", k, 32'(o_ra), 0);
      chk("rst_wr_addr", k, 32'(o_wa), 0);
      chk("rst_out_addr", k, 32'(o_oa), 0);
      chk("rst_pass_idx", k, 32'(o_pidx), 0);
    end
`ifdef MACSEQ_STALL_CNT_EN
    if (e_scchk[k] && !sel) chk("stall_cnt", k, sc_a, e_sc[k]);
`endif
  endtask

  initial begin
    int s, d, kc, last;
    for (int i = 0; i < NC; i++) vpat[i] = 1'b1;
    vrst[1] = 1'b1;
    vrst[2] = 1'b1;
    ia.start = 1'b0; ia.in_valid = 1'b0;
    ib.start = 1'b0; ib.in_valid = 1'b0;

    // in_valid held high
    s = 4;
    plan(s, 4, 3, NC, d);
    // extra start pulses while streaming are ignored
    s = d + 3;
    vstart[s+4] = 1'b1;
    vstart[s+20] = 1'b1;
    plan(s, 4, 3, NC, d);
    // in_valid toggling 1,0,1,0
    s = d + 3;
    for (int x = s + 1; x <= s + 150; x++) vpat[x] = ((x - s) % 2) == 1;
    plan(s, 4, 3, NC, d);
    // five starved cycles in LOAD/STREAM of pass 0
    s = d + 3;
    vpat[s+1] = 1'b0; vpat[s+3] = 1'b0; vpat[s+4] = 1'b0; vpat[s+6] = 1'b0; vpat[s+7] = 1'b0;
    plan(s, 4, 3, NC, d);
    // random gaps
    s = d + 3;
    for (int x = s + 1; x <= s + 200; x++) vpat[x] = ($urandom_range(3, 0) != 0);
    plan(s, 4, 3, NC, d);
    // reset at the accept of element 1 in pass 1
    s = d + 3;
    plan(s, 4, 3, NC, d);
    kc = acc_cyc[1*4 + 1];
    clear_exp(s, d + 1);
    plan(s, 4, 3, kc, d);
    for (int x = kc; x <= kc + 2; x++) vrst[x] = 1'b1;
    for (int x = kc + 1; x <= kc + 3; x++) e_zero[x] = 1'b1;
    // full product after the reset
    s = kc + 6;
    plan(s, 4, 3, NC, d);
    // single-pass configuration
    s = d + 3;
    for (int x = s; x < NC; x++) vsel[x] = 1'b1;
    plan(s, 2, 1, NC, d);
    last = d + 5;

    for (int k = 1; k <= last; k++) begin
      @(posedge clk);
      #1;
      check_cycle(k);
      ia.start    = vstart[k] && !vsel[k];
      ib.start    = vstart[k] && vsel[k];
      ia.in_valid = vpat[k];
      ib.in_valid = vpat[k];
      rst         = vrst[k];
      #1;
      chk("load_const", k, 32'(o_lc), 32'(e_lc[k]));
      sel = vsel[k+1];
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
